sprite_compositor: RTL

//  N-channel sprite overlay stage for the 1024x768@60 (65 MHz) VGA pipeline. Sits after draw_background on the VGA bus.

---
 rtl/sprite_compositor_pkg.sv | 22 ++
 rtl/sprite_compositor_channel.sv | 50 +++++
 rtl/sprite_compositor.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor: VGA bus layout and sprite position width.
package sprite_compositor_pkg;

  localparam int unsigned SPR_POS_W = 12;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        hblnk;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_bus_t;

  localparam int unsigned VGA_BUS_SIZE = $bits(vga_bus_t);

  function automatic logic vga_blank(input vga_bus_t b);
    return b.hblnk | b.vblnk;
  endfunction

endpackage

// File: rtl/sprite_compositor_channel.sv
// One sprite channel: S1 hit test and ROM address, plus the hit delayed into S2.
module sprite_channel
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned SPR_W = 64,
  parameter int unsigned SPR_H = 64,
  parameter int unsigned AW    = 12
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic [SPR_POS_W-1:0] i_xpos,
  input  logic [SPR_POS_W-1:0] i_ypos,
  input  logic [SPR_POS_W-1:0] i_hcount,
  input  logic [SPR_POS_W-1:0] i_vcount,
  input  logic                 i_blank,
  output logic [AW-1:0]        o_rom_addr,
  output logic                 o_hit_s2
);

  logic [SPR_POS_W-1:0] w_rx;
  logic [SPR_POS_W-1:0] w_ry;
  logic                 w_hit;
  logic [AW-1:0]        w_addr;
  logic                 r_hit_s1;
  logic                 r_hit_s2;
  logic [AW-1:0]        r_addr;

  // Unsigned wrap makes pixels left of / above the sprite look far away.
  assign w_rx   = i_hcount - i_xpos;
  assign w_ry   = i_vcount - i_ypos;
  assign w_hit  = i_en & (32'(w_rx) < SPR_W) & (32'(w_ry) < SPR_H) & ~i_blank;
  assign w_addr = AW'(w_ry) * AW'(SPR_W) + AW'(w_rx);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_hit_s1 <= 1'b0;
      r_hit_s2 <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_hit_s1 <= w_hit;
      r_hit_s2 <= r_hit_s1;
      r_addr   <= w_hit ? w_addr : '0;
    end
  end

  assign o_rom_addr = r_addr;
  assign o_hit_s2   = r_hit_s2;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite overlay with fixed priority (channel 0 on top), 3-cycle bus latency.
// Optional per-frame collision flags built when SPRITE_COLLISION_EN is defined.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int unsigned N_SPR   = 2,
  parameter int unsigned SPR_W   = 64,
  parameter int unsigned SPR_H   = 64,
  parameter logic [11:0] KEY_RGB = 12'hF0F,
  localparam int unsigned AW     = $clog2(SPR_W * SPR_H)
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [VGA_BUS_SIZE-1:0]    vga_in,
  input  logic [N_SPR-1:0]           spr_en,
  input  logic [SPR_POS_W*N_SPR-1:0] spr_xpos,
  input  logic [SPR_POS_W*N_SPR-1:0] spr_ypos,
  output logic [AW*N_SPR-1:0]        rom_addr,
  input  logic [12*N_SPR-1:0]        rom_rgb,
  output logic [N_SPR-1:0]           coll_flags,
  output logic [VGA_BUS_SIZE-1:0]    vga_out
);

  vga_bus_t                   w_in;
  vga_bus_t                   w_out;
  vga_bus_t                   r_bus_s1;
  vga_bus_t                   r_bus_s2;
  vga_bus_t                   r_out;
  logic                       r_vblnk_d;
  logic                       w_vblnk_rise;
  logic [N_SPR-1:0]           r_en_sh;
  logic [SPR_POS_W*N_SPR-1:0] r_xpos_sh;
  logic [SPR_POS_W*N_SPR-1:0] r_ypos_sh;
  logic [N_SPR-1:0]           w_hit_s2;
  logic [N_SPR-1:0]           w_opaque;

  assign w_in         = vga_bus_t'(vga_in);
  assign w_vblnk_rise = w_in.vblnk & ~r_vblnk_d;

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_vblnk_d <= 1'b0;
      r_en_sh   <= '0;
      r_xpos_sh <= '0;
      r_ypos_sh <= '0;
      r_bus_s1  <= '0;
      r_bus_s2  <= '0;
      r_out     <= '0;
    end else begin
      r_vblnk_d <= w_in.vblnk;
      if (w_vblnk_rise) begin
        r_en_sh   <= spr_en;
        r_xpos_sh <= spr_xpos;
        r_ypos_sh <= spr_ypos;
      end
      r_bus_s1 <= w_in;
      r_bus_s2 <= r_bus_s1;
      r_out    <= w_out;
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_ch
    sprite_channel #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .AW    (AW)
    ) u_ch (
      .pclk       (pclk),
      .rst        (rst),
      .i_en       (r_en_sh[g]),
      .i_xpos     (r_xpos_sh[SPR_POS_W*g +: SPR_POS_W]),
      .i_ypos     (r_ypos_sh[SPR_POS_W*g +: SPR_POS_W]),
      .i_hcount   (w_in.hcount),
      .i_vcount   (w_in.vcount),
      .i_blank    (vga_blank(w_in)),
      .o_rom_addr (rom_addr[AW*g +: AW]),
      .o_hit_s2   (w_hit_s2[g])
    );
    assign w_opaque[g] = w_hit_s2[g] & (rom_rgb[12*g +: 12] != KEY_RGB);
  end

  // Walk from lowest priority up so the lowest-index opaque channel is the last writer.
  always_comb begin
    w_out = r_bus_s2;
    if (vga_blank(r_bus_s2)) begin
      w_out.rgb = '0;
    end else begin
      for (int i = N_SPR - 1; i >= 0; i--) begin
        if (w_opaque[i]) w_out.rgb = rom_rgb[12*i +: 12];
      end
    end
  end

  assign vga_out = r_out;

`ifdef SPRITE_COLLISION_EN
  logic [N_SPR-1:0] w_coll_now;
  logic [N_SPR-1:0] r_acc;
  logic [N_SPR-1:0] r_coll;

  always_comb begin
    w_coll_now = '0;
    for (int i = 0; i < N_SPR; i++) begin
      w_coll_now[i] = w_opaque[i] & (|(w_opaque & ~(N_SPR'(1) << i)));
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_coll <= '0;
    end else if (w_vblnk_rise) begin
      r_coll <= r_acc | w_coll_now;
      r_acc  <= '0;
    end else begin
      r_acc <= r_acc | w_coll_now;
    end
  end

  assign coll_flags = r_coll;
`else
  assign coll_flags = '0;
`endif

endmodule
